// File: rtl/pwm_hold_gen.sv
// pwm_hold_gen: five-slot PWM generator driven by a thermometer hold code.
// The hold code is captured into a shadow register only at period
// boundaries (or continuously while idle) so the output never shows a
// runt pulse when the selector changes mid-period.
module pwm_hold_gen #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    input  logic [4:0]       h,
    output logic             pwm,
    output logic [2:0]       slot,
    output logic             period_start,
    output logic             h_err
);

    // Generator state: idle (en low) or running a period sequence.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [2:0]       slot_q;
    logic [2:0]       slot_d;
    logic [4:0]       shadow_q;
    logic [4:0]       shadow_d;
    logic             pwm_q;
    logic             pwm_d;
    logic             period_start_q;
    logic             period_start_d;
    logic             h_err_q;
    logic             h_err_d;

    logic             tick;
    logic             boundary;
    logic             h_valid;
    logic [4:0]       slot_mask;

    // Only the six thermometer patterns are accepted as hold codes.
    function automatic logic is_therm(input logic [4:0] code);
        logic ok;
        case (code)
            5'b00000, 5'b00001, 5'b00011,
            5'b00111, 5'b01111, 5'b11111: ok = 1'b1;
            default:                      ok = 1'b0;
        endcase
        return ok;
    endfunction

    // State register plus all datapath flops, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            slot_q         <= 3'd0;
            shadow_q       <= 5'b00000;
            pwm_q          <= 1'b0;
            period_start_q <= 1'b0;
            h_err_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            slot_q         <= slot_d;
            shadow_q       <= shadow_d;
            pwm_q          <= pwm_d;
            period_start_q <= period_start_d;
            h_err_q        <= h_err_d;
        end
    end

    // Next state: the generator runs whenever en is high.
    always_comb begin
        state_d = ST_IDLE;
        if (en) begin
            state_d = ST_RUN;
        end
    end

    // Prescaler, slot counter, shadow load and output computation.
    always_comb begin
        cnt_d          = '0;
        slot_d         = 3'd0;
        shadow_d       = shadow_q;
        period_start_d = 1'b0;
        h_err_d        = h_err_q;
        h_valid        = is_therm(h);
        // >= rather than == so that shrinking div mid-slot ends the slot at once.
        tick           = (cnt_q >= div);
        boundary       = 1'b0;

        if (!en) begin
            // Idle: everything parked, shadow tracks any valid code, flag cleared.
            h_err_d = 1'b0;
            if (h_valid) begin
                shadow_d = h;
            end
        end else if (state_q == ST_IDLE) begin
            // First enabled clock: open slot 0 with the code captured while idle.
            period_start_d = 1'b1;
        end else if (tick) begin
            slot_d   = (slot_q == 3'd4) ? 3'd0 : slot_q + 3'd1;
            boundary = (slot_q == 3'd4);
            if (boundary) begin
                period_start_d = 1'b1;
                if (h_valid) begin
                    shadow_d = h;
                end else begin
                    h_err_d = 1'b1;
                end
            end
        end else begin
            cnt_d  = cnt_q + 1'b1;
            slot_d = slot_q;
        end
    end

    // Output comb: pwm uses next-state slot and shadow so all three move together.
    always_comb begin
        slot_mask = 5'b00001 << slot_d;
        pwm_d     = en & (|(shadow_d & slot_mask));
    end

    assign pwm          = pwm_q;
    assign slot         = slot_q;
    assign period_start = period_start_q;
    assign h_err        = h_err_q;

endmodule

// File: tb/tb_pwm_hold_gen.sv
// Self-checking bench for pwm_hold_gen: directed scenarios plus a random run,
// all compared against a slot/duty-level reference model.
module tb_pwm_hold_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [7:0] div = 8'd0;
    logic [4:0] h   = 5'b00000;
    logic       pwm;
    logic [2:0] slot;
    logic       period_start;
    logic       h_err;

    int n_tests = 0;
    int n_fail  = 0;

    pwm_hold_gen #(.DIV_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .div          (div),
        .h            (h),
        .pwm          (pwm),
        .slot         (slot),
        .period_start (period_start),
        .h_err        (h_err)
    );

    always #5 clk = ~clk;

    function automatic int popc(input logic [4:0] v);
        int c = 0;
        for (int b = 0; b < 5; b++) c += int'(v[b]);
        return c;
    endfunction

    // A valid code is a run of ones starting at bit 0.
    function automatic bit valid_code(input logic [4:0] v);
        int ones = (1 << popc(v)) - 1;
        return int'(v) == ones;
    endfunction

    // Reference model: tracks how many clocks the current slot has been shown,
    // which slot of the period is showing, and the latched duty (as a code).
    bit       m_run;
    int       m_age;
    int       m_slot;
    logic [4:0] m_shadow;
    logic     exp_pwm, exp_ps, exp_err;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run = 0; m_age = 0; m_slot = 0; m_shadow = 5'b0;
            exp_pwm = 0; exp_ps = 0; exp_err = 0;
        end else if (!en) begin
            m_run = 0; m_age = 0; m_slot = 0;
            exp_pwm = 0; exp_ps = 0; exp_err = 0;
            if (valid_code(h)) m_shadow = h;
        end else if (!m_run) begin
            m_run = 1; m_age = 1; m_slot = 0; exp_ps = 1;
            exp_pwm = (popc(m_shadow) > 0);
        end else begin
            exp_ps = 0;
            if (m_age >= int'(div) + 1) begin
                m_age  = 1;
                m_slot = (m_slot + 1) % 5;
                if (m_slot == 0) begin
                    exp_ps = 1;
                    if (valid_code(h)) m_shadow = h;
                    else exp_err = 1;
                end
            end else begin
                m_age++;
            end
            exp_pwm = (m_slot < popc(m_shadow));
        end
    end

    task automatic test_reset();
        #1;
        n_tests++;
        if (pwm !== 1'b0 || slot !== 3'd0 || period_start !== 1'b0 || h_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: got pwm=%b slot=%0d ps=%b err=%b required 0 0 0 0",
                     pwm, slot, period_start, h_err);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        $display("[TB] reset checked");
    endtask

    task automatic test_basic();
        en = 1'b0; div = 8'd0; h = 5'b00011;
        @(negedge clk);
        en = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            n_tests++;
            if (pwm !== ((i % 5) < 2) || period_start !== ((i % 5) == 0) || slot !== 3'(i % 5)) begin
                n_fail++;
                $display("FAIL basic_40pct clk%0d: got pwm=%b ps=%b slot=%0d required pwm=%b ps=%b slot=%0d",
                         i, pwm, period_start, slot, (i % 5) < 2, (i % 5) == 0, i % 5);
            end
        end
        $display("[TB] basic 40%% duty checked");
    endtask

    task automatic test_divider();
        int high = 0;
        en = 1'b0; div = 8'd3; h = 5'b00111;
        @(negedge clk);
        en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            high += int'(pwm);
            n_tests++;
            if (slot !== 3'((i / 4) % 5) || pwm !== exp_pwm) begin
                n_fail++;
                $display("FAIL divider clk%0d: got slot=%0d pwm=%b required slot=%0d pwm=%b",
                         i, slot, pwm, (i / 4) % 5, exp_pwm);
            end
        end
        n_tests++;
        if (high != 24) begin
            n_fail++;
            $display("FAIL divider_high: got %0d high clocks required 24", high);
        end
        $display("[TB] divider 20-clock period: %0d high of 40", high);
    endtask

    task automatic test_boundary_update();
        int hi2 = 0;
        int hi3 = 0;
        en = 1'b0; div = 8'd1; h = 5'b00001;
        @(negedge clk);
        en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i >= 10 && i < 20) hi2 += int'(pwm);
            if (i >= 20) hi3 += int'(pwm);
            n_tests++;
            if (pwm !== exp_pwm || slot !== 3'(m_slot)) begin
                n_fail++;
                $display("FAIL boundary_update clk%0d: got pwm=%b slot=%0d required pwm=%b slot=%0d",
                         i, pwm, slot, exp_pwm, m_slot);
            end
            if (i == 14) h = 5'b01111;
        end
        n_tests++;
        if (hi2 != 2 || hi3 != 8) begin
            n_fail++;
            $display("FAIL boundary_update_high: got %0d/%0d required 2/8", hi2, hi3);
        end
        $display("[TB] boundary update: %0d then %0d high of 10", hi2, hi3);
    endtask

    task automatic test_invalid();
        en = 1'b0; div = 8'd0; h = 5'b00011;
        @(negedge clk);
        en = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            n_tests++;
            if (h_err !== (i >= 5) || pwm !== ((i % 5) < 2)) begin
                n_fail++;
                $display("FAIL invalid_code clk%0d: got err=%b pwm=%b required err=%b pwm=%b",
                         i, h_err, pwm, i >= 5, (i % 5) < 2);
            end
            if (i == 2) h = 5'b00101;
        end
        en = 1'b0;
        @(negedge clk);
        n_tests++;
        if (h_err !== 1'b0 || pwm !== 1'b0) begin
            n_fail++;
            $display("FAIL invalid_clear: got err=%b pwm=%b required 0 0", h_err, pwm);
        end
        @(negedge clk);
        n_tests++;
        if (h_err !== 1'b0) begin
            n_fail++;
            $display("FAIL invalid_idle_noflag: got err=%b required 0", h_err);
        end
        $display("[TB] invalid code flag checked");
    endtask

    task automatic test_extremes();
        int hi = 0;
        en = 1'b0; div = 8'd2; h = 5'b11111;
        @(negedge clk);
        en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            hi += int'(pwm);
        end
        n_tests++;
        if (hi != 30) begin
            n_fail++;
            $display("FAIL full_duty: got %0d high clocks required 30", hi);
        end
        en = 1'b0; h = 5'b00000;
        @(negedge clk);
        en = 1'b1;
        hi = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            hi += int'(pwm);
        end
        n_tests++;
        if (hi != 0) begin
            n_fail++;
            $display("FAIL zero_duty: got %0d high clocks required 0", hi);
        end
        $display("[TB] extremes checked");
    endtask

    task automatic test_div_change();
        int req;
        en = 1'b0; div = 8'd7; h = 5'b00011;
        @(negedge clk);
        en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            req = (i <= 5) ? 0 : (i <= 8) ? 1 : 2;
            n_tests++;
            if (slot !== 3'(req) || pwm !== exp_pwm) begin
                n_fail++;
                $display("FAIL div_change clk%0d: got slot=%0d pwm=%b required slot=%0d pwm=%b",
                         i, slot, pwm, req, exp_pwm);
            end
            if (i == 5) div = 8'd2;
        end
        $display("[TB] mid-slot div decrease checked");
    endtask

    task automatic test_reset_mid();
        en = 1'b0; div = 8'd1; h = 5'b01111;
        @(negedge clk);
        en = 1'b1;
        repeat (7) @(negedge clk);
        n_tests++;
        if (slot !== 3'd3 || pwm !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_pre: got slot=%0d pwm=%b required 3 1", slot, pwm);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (pwm !== 1'b0 || slot !== 3'd0 || period_start !== 1'b0 || h_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got pwm=%b slot=%0d ps=%b err=%b required 0 0 0 0",
                     pwm, slot, period_start, h_err);
        end
        h = 5'b00001;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_tests++;
            if (pwm !== (i == 10 || i == 11) || period_start !== (i == 0 || i == 10)) begin
                n_fail++;
                $display("FAIL reset_mid_resume clk%0d: got pwm=%b ps=%b required pwm=%b ps=%b",
                         i, pwm, period_start, i == 10 || i == 11, i == 0 || i == 10);
            end
        end
        $display("[TB] async reset mid-period checked");
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 199) == 0) rst = 1'b1;
            if ($urandom_range(0, 29) == 0) en = ~en;
            if ($urandom_range(0, 49) == 0) div = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) h = 5'((1 << $urandom_range(0, 5)) - 1);
            else h = 5'($urandom);
            @(negedge clk);
            n_tests++;
            if (pwm !== exp_pwm || slot !== 3'(m_slot) || period_start !== exp_ps || h_err !== exp_err) begin
                n_fail++;
                $display("FAIL random clk%0d: got pwm=%b slot=%0d ps=%b err=%b required pwm=%b slot=%0d ps=%b err=%b",
                         i, pwm, slot, period_start, h_err, exp_pwm, m_slot, exp_ps, exp_err);
            end
        end
        rst = 1'b0;
        $display("[TB] random run checked");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_divider();
        test_boundary_update();
        test_invalid();
        test_extremes();
        test_div_change();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_hold_gen.md
# pwm_hold_gen

Slot-based PWM generator that consumes the 5-bit thermometer hold code produced by the selector decoder and drives the PWM output pin. A period is five equal slots. The output is high in slot *k* when hold bit *k* is set, so the duty cycle is 0/20/40/60/80/100 %. The hold code is double-buffered and updated only at period boundaries, so a selector change never produces a runt pulse.

## Interface
Parameters:
- DIV_W, 8, width of the slot-length divider input.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- en  input  1  run enable; low holds the generator idle.
- div  input  DIV_W  slot length minus one, in clocks; one slot lasts div+1 clocks.
- h  input  5  thermometer hold code from the decoder.
- pwm  output  1  PWM output, registered.
- slot  output  3  current slot index, 0..4.
- period_start  output  1  one-clock pulse in the first clock of every period.
- h_err  output  1  sticky flag: a non-thermometer code was presented at a period boundary.

## Operation
- Reset values: internal prescaler count cnt=0, slot=0, shadow=00000, pwm=0, period_start=0, h_err=0.
- Valid codes: 00000, 00001, 00011, 00111, 01111, 11111. All other 26 values are invalid.
- Prescaler:
  - Runs only while en=1.
  - Asserts an internal tick when cnt >= div; cnt then returns to 0.
  - Otherwise cnt increments.
  - The >= compare makes a mid-slot decrease of div end the current slot on the next clock. An increase of div lengthens the current slot.
- Slot counter:
  - Advances on each tick: 4 -> 0, otherwise +1.
  - The tick taking slot 4 -> 0 is the period boundary.
- Shadow load at a period boundary while en=1:
  - Valid h: shadow <= h.
  - Invalid h: shadow keeps its value and h_err <= 1.
- Idle state, en=0:
  - cnt=0, slot=0, pwm=0, period_start=0, h_err cleared.
  - shadow loads every valid h each clock. Invalid h is ignored and not flagged.
- Invariant while en=1: pwm equals shadow[slot], both as registered values. pwm is computed from next-state values, so pwm, slot and shadow change on the same edge.
- period_start=1 for exactly one clock when slot enters 0 at a boundary. It also pulses on the first clock after en rises.
- div=0 is legal: 1-clock slots, 5-clock period.

## Timing
- en rise at edge E0: slot 0 begins at E0+1 with pwm=shadow[0] and period_start=1. The first period uses the code loaded while idle.
- Steady state: period = 5*(div+1) clocks; high time = popcount(shadow)*(div+1) clocks, contiguous from slot 0.
- h change latency: takes effect at the next period boundary, at most 5*(div+1) clocks later. There is no effect mid-period.
- en fall: pwm=0 and slot=0 at the next edge. The period is truncated, with no completion.
- Asynchronous rst mid-period: all outputs take their reset values immediately. Operation resumes on the first clock after rst deasserts, as an en rise if en=1.
- Invalid h at a boundary together with en falling: the en=0 rules win. No flag is raised and h_err is cleared.

## Test plan
- Basic 40 % duty: rst pulse, div=0, h=00011, en=1 -> 5-clock period, pwm pattern 1,1,0,0,0 repeating; period_start every 5th clock, aligned with slot=0.
- Divider: div=3, h=00111 -> 20-clock period; pwm high 12 clocks, low 8; slot holds each value 4 clocks.
- Boundary update: div=1, h=00001 running; change h to 01111 during slot 2 -> the current period still shows 2 high clocks; the next period shows 8 high of 10.
- Invalid code: h=00101 at a boundary with shadow=00011 -> h_err=1 from the next clock; pwm keeps the 00011 pattern; en low for 1 clock -> h_err=0.
- Extremes and mid-run div change: h=11111 -> pwm constantly 1 across boundaries with no glitch; h=00000 -> pwm constantly 0; div changed 7 -> 2 at cnt=5 -> slot advances on the next clock.
- Reset mid-operation: assert rst asynchronously in slot 3 with pwm=1 -> pwm=0, slot=0 and shadow=00000 without a clock edge; release with en=1, h=00001 -> pwm=0 for the whole first period (shadow was 00000), then pwm=1 in slot 0 from the second period.
